// File: rtl/jtpopeye_prom_loader.sv
// jtpopeye_prom_loader: turns the ioctl download stream into colour-PROM write strobes.
// Optional checksum checking is enabled by defining JTPOPEYE_PROM_CHK_EN.
module jtpopeye_prom_loader #(
    parameter logic [21:0] PROM_START = 22'h0,
    parameter int unsigned WE_LEN     = 2,
    parameter logic [7:0]  PROM_CHK   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [7:0]  prog_addr,
    output logic [7:0]  prom_din,
    output logic        prom_4a_we,
    output logic        prom_3a_we,
    output logic        prom_5b_we,
    output logic        prom_5a_we,
    output logic        prom_done,
    output logic        overrun,
    output logic        chk_ok
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [3:0] WE_INIT = 4'(WE_LEN);
    state_t st, st_nxt;
    logic dl_prev;
    logic [3:0] we_cnt;
    logic [1:0] rgn, iss_rgn;
    logic pend_v;
    logic [9:0] pend_off, iss_off, iss_base, cnt;
    logic [7:0] pend_data, iss_data;
    logic [22:0] diff;
    logic in_rng, acc, start, active, issue_pend, issue_new, issue, drained;
    // Borrow bit of the widened subtraction flags addresses below PROM_START.
    assign diff       = {1'b0, ioctl_addr} - {1'b0, PROM_START};
    assign in_rng     = !diff[22] && diff[21:0] < 22'h240;
    assign acc        = ioctl_wr && downloading && in_rng;
    assign start      = downloading && !dl_prev;
    assign active     = we_cnt != 4'd0;
    assign drained    = !active && !pend_v;
    assign issue_pend = !active && pend_v;
    assign issue_new  = !active && !pend_v && acc;
    assign issue      = issue_pend || issue_new;
    assign iss_off    = issue_pend ? pend_off : diff[9:0];
    assign iss_data   = issue_pend ? pend_data : ioctl_data;
    assign iss_rgn    = iss_off < 10'h020 ? 2'd0 : iss_off < 10'h040 ? 2'd1 :
                        iss_off < 10'h140 ? 2'd2 : 2'd3;
    assign iss_base   = iss_rgn == 2'd0 ? 10'h000 : iss_rgn == 2'd1 ? 10'h020 :
                        iss_rgn == 2'd2 ? 10'h040 : 10'h140;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end
    always_comb begin
        st_nxt = start ? LOAD :
                 (st == LOAD && !downloading && drained) ? (cnt == 10'd576 ? DONE : IDLE) : st;
    end
    always_comb begin
        prom_done = st == DONE;
        {prom_5a_we, prom_5b_we, prom_3a_we, prom_4a_we} = active ? 4'b0001 << rgn : 4'b0000;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_prev   <= 1'b0;
            we_cnt    <= 4'd0;
            rgn       <= 2'd0;
            prog_addr <= 8'd0;
            prom_din  <= 8'd0;
            pend_v    <= 1'b0;
            pend_off  <= 10'd0;
            pend_data <= 8'd0;
            overrun   <= 1'b0;
            cnt       <= 10'd0;
        end else begin
            dl_prev <= downloading;
            we_cnt  <= issue ? WE_INIT : active ? we_cnt - 4'd1 : 4'd0;
            if (issue) begin
                rgn       <= iss_rgn;
                prog_addr <= 8'(iss_off - iss_base);
                prom_din  <= iss_data;
            end
            pend_v <= issue_pend ? acc : pend_v || (active && acc);
            if (issue_pend ? acc : (active && acc && !pend_v)) begin
                pend_off  <= diff[9:0];
                pend_data <= ioctl_data;
            end
            overrun <= !start && (overrun || (active && acc && pend_v));
            cnt     <= start ? 10'(issue) : cnt + 10'(issue && cnt != 10'd576);
        end
    end
`ifdef JTPOPEYE_PROM_CHK_EN
    logic [7:0] sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum    <= 8'd0;
            chk_ok <= 1'b0;
        end else begin
            sum <= (start ? 8'd0 : sum) + (issue ? iss_data : 8'd0);
            if (start) chk_ok <= 1'b0;
            else if (st_nxt == DONE && st != DONE) chk_ok <= sum == PROM_CHK;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^PROM_CHK;
    assign chk_ok = 1'b1;
`endif
endmodule

// File: tb/tb_jtpopeye_prom_loader.sv
// tb_jtpopeye_prom_loader: table vectors, directed corner cases and random stream
// checked against a timing-level model of strobe issue / pending / drop rules.
module tb_jtpopeye_prom_loader;
    localparam int W = 2;
    logic clk = 0, rst_n = 0, downloading = 0, ioctl_wr = 0;
    logic [21:0] ioctl_addr = 0;
    logic [7:0] ioctl_data = 0;
    logic [7:0] pa1, din1, pa2, din2;
    logic a4_1, a3_1, b5_1, a5_1, done1, ovr1, chk1;
    logic a4_2, a3_2, b5_2, a5_2, done2, ovr2, chk2;
    logic [3:0] we1, we2;
    assign we1 = {a5_1, b5_1, a3_1, a4_1};
    assign we2 = {a5_2, b5_2, a3_2, a4_2};
    always #5 clk = ~clk;

    jtpopeye_prom_loader #(.PROM_START(22'h0), .WE_LEN(W), .PROM_CHK(8'h40)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(pa1), .prom_din(din1),
        .prom_4a_we(a4_1), .prom_3a_we(a3_1), .prom_5b_we(b5_1), .prom_5a_we(a5_1),
        .prom_done(done1), .overrun(ovr1), .chk_ok(chk1));
    jtpopeye_prom_loader #(.PROM_START(22'h8000), .WE_LEN(W), .PROM_CHK(8'h40)) dut2 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(pa2), .prom_din(din2),
        .prom_4a_we(a4_2), .prom_3a_we(a3_2), .prom_5b_we(b5_2), .prom_5a_we(a5_2),
        .prom_done(done2), .overrun(ovr2), .chk_ok(chk2));

    typedef struct packed {int start; int rgn; logic [7:0] addr; logic [7:0] data; int len;} wr_t;
    typedef struct {logic [21:0] a; logic [7:0] d; logic [3:0] we; logic [7:0] pa;} vec_t;

    int cyc = 0, total = 0, passed = 0;
    int multi = 0, unstable = 0;
    wr_t obs[$], exp_q[$], cur, m_pr;
    logic cur_on = 0;
    int m_s, m_p, m_drops;
    logic [7:0] m_sum;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor for the PROM_START=0 instance: one record per strobe.
    always @(negedge clk) begin
        if ($countones(we1) > 1) multi <= multi + 1;
        if (|we1) begin
            if (!cur_on) begin
                cur = '{start: cyc, rgn: a4_1 ? 0 : a3_1 ? 1 : b5_1 ? 2 : 3, addr: pa1, data: din1, len: 1};
                cur_on = 1;
            end else begin
                cur.len = cur.len + 1;
                if (pa1 != cur.addr || din1 != cur.data) unstable <= unstable + 1;
            end
        end else if (cur_on) begin
            obs.push_back(cur);
            cur_on = 0;
        end
    end

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    function automatic int exp_chk(input logic loaded);
`ifdef JTPOPEYE_PROM_CHK_EN
        return (loaded && m_sum == 8'h40) ? 1 : 0;
`else
        return loaded ? 1 : 1;
`endif
    endfunction

    task automatic commit(input int s, input wr_t r);
        r.start = s;
        r.len = W;
        exp_q.push_back(r);
        m_s = s;
        m_sum = m_sum + r.data;
    endtask

    // Edge t: the clock edge at which ioctl_wr is sampled.
    task automatic model(input int t, input logic [21:0] a, input logic [7:0] d);
        int off;
        wr_t r;
        if (a >= 22'h240) return;
        off = int'(a);
        r.data = d;
        r.start = 0;
        r.len = W;
        if (off < 32) begin r.rgn = 0; r.addr = 8'(off); end
        else if (off < 64) begin r.rgn = 1; r.addr = 8'(off - 32); end
        else if (off < 320) begin r.rgn = 2; r.addr = 8'(off - 64); end
        else begin r.rgn = 3; r.addr = 8'(off - 320); end
        if (m_p >= 0 && t < m_p) begin m_drops++; return; end
        if (m_p >= 0) begin commit(m_p, m_pr); m_p = -1; end
        if (t > m_s + W) commit(t, r);
        else begin m_p = m_s + W + 1; m_pr = r; end
    endtask

    task automatic wr(input logic [21:0] a, input logic [7:0] d, input int gap);
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1;
        model(cyc + 1, a, d);
        @(negedge clk);
        ioctl_wr = 0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic begin_session();
        m_s = -100; m_p = -1; m_drops = 0; m_sum = 0;
        exp_q.delete();
        downloading = 1;
        repeat (2) @(negedge clk);
        obs.delete();
    endtask

    task automatic end_session();
        if (m_p >= 0) begin commit(m_p, m_pr); m_p = -1; end
        downloading = 0;
        repeat (4 * W + 8) @(negedge clk);
    endtask

    task automatic cmp_q(input string nm);
        int bad = 0;
        check({nm, " strobes"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (obs[i] != exp_q[i]) bad++;
        check({nm, " fields"}, bad, 0);
    endtask

    task automatic stream(input int n, input logic [7:0] special);
        for (int i = 0; i < n; i++) wr(22'(i), i == 'h145 ? special : 8'h01, 4);
    endtask

    initial begin
        vec_t tbl[10];
        int rc[4];
        tbl[0] = '{22'h000, 8'h10, 4'b0001, 8'h00};
        tbl[1] = '{22'h01F, 8'h11, 4'b0001, 8'h1F};
        tbl[2] = '{22'h020, 8'h12, 4'b0010, 8'h00};
        tbl[3] = '{22'h03F, 8'h13, 4'b0010, 8'h1F};
        tbl[4] = '{22'h040, 8'h14, 4'b0100, 8'h00};
        tbl[5] = '{22'h13F, 8'h15, 4'b0100, 8'hFF};
        tbl[6] = '{22'h140, 8'h16, 4'b1000, 8'h00};
        tbl[7] = '{22'h23F, 8'h17, 4'b1000, 8'hFF};
        tbl[8] = '{22'h240, 8'h18, 4'b0000, 8'h00};
        tbl[9] = '{22'h3FFFFF, 8'h19, 4'b0000, 8'h00};
        m_s = -100; m_p = -1; m_drops = 0; m_sum = 0;
        repeat (3) @(negedge clk);
        check("reset we", int'(we1), 0);
        check("reset addr/din", int'({pa1, din1}), 0);
        check("reset done/ovr", int'({done1, ovr1}), 0);
        check("reset chk_ok", int'(chk1), exp_chk(0));
        rst_n = 1;
        @(negedge clk);

        begin_session();
        for (int i = 0; i < 10; i++) begin
            wr(tbl[i].a, tbl[i].d, 1);
            check("tbl we", int'(we1), int'(tbl[i].we));
            if (tbl[i].we != 0) begin
                check("tbl addr", int'(pa1), int'(tbl[i].pa));
                check("tbl din", int'(din1), int'(tbl[i].d));
            end
            repeat (W + 3) @(negedge clk);
        end
        end_session();
        cmp_q("table");
        check("table overrun", int'(ovr1), 0);

        begin_session();
        wr(22'h020, 8'h11, 1);
        wr(22'h021, 8'h22, 1);
        wr(22'h022, 8'h33, 1);
        repeat (8) @(negedge clk);
        check("b2b overrun", int'(ovr1), 1);
        end_session();
        cmp_q("b2b");
        check("b2b issued", obs.size(), 2);
        check("b2b second addr", obs.size() > 1 ? int'(obs[1].addr) : -1, 1);
        check("b2b done", int'(done1), 0);

        begin_session();
        for (int i = 0; i < 200; i++)
            wr(22'($urandom_range(0, 'h2FF)), 8'($urandom), int'($urandom_range(1, 5)));
        end_session();
        cmp_q("random");
        check("random overrun", int'(ovr1), m_drops > 0 ? 1 : 0);
        check("random done", int'(done1), 0);

        begin_session();
        stream(575, 8'h01);
        end_session();
        check("575 done", int'(done1), 0);
        check("575 chk_ok", int'(chk1), exp_chk(0));

        begin_session();
        stream(576, 8'h01);
        end_session();
        cmp_q("stream1");
        check("stream1 done", int'(done1), 1);
        check("stream1 chk_ok", int'(chk1), exp_chk(1));
        rc = '{0, 0, 0, 0};
        foreach (obs[i]) rc[obs[i].rgn & 3]++;
        check("count 4a", rc[0], 32);
        check("count 3a", rc[1], 32);
        check("count 5b", rc[2], 256);
        check("count 5a", rc[3], 256);

        begin_session();
        check("restart done", int'(done1), 0);
        check("restart chk_ok", int'(chk1), exp_chk(0));
        stream(576, 8'hA7);
        end_session();
        cmp_q("stream2");
        check("stream2 done", int'(done1), 1);
        check("stream2 chk_ok", int'(chk1), exp_chk(1));
        check("byte145 rgn", obs.size() > 325 ? obs[325].rgn : -1, 3);
        check("byte145 addr", obs.size() > 325 ? int'(obs[325].addr) : -1, 5);
        check("byte145 data", obs.size() > 325 ? int'(obs[325].data) : -1, 'hA7);

        begin_session();
        wr(22'h7FFF, 8'h99, 1);
        check("below start we", int'(we2), 0);
        repeat (W + 3) @(negedge clk);
        wr(22'h8240, 8'h98, 1);
        check("above end we", int'(we2), 0);
        repeat (W + 3) @(negedge clk);
        wr(22'h8000, 8'h5C, 1);
        check("offset we", int'(we2), 1);
        check("offset addr", int'(pa2), 0);
        check("offset din", int'(din2), 'h5C);
        end_session();

        begin_session();
        wr(22'h050, 8'h3C, 1);
        check("pre-reset 5b", int'(b5_1), 1);
        #2 rst_n = 0;
        #1;
        check("async 5b drop", int'(b5_1), 0);
        check("async we", int'(we1), 0);
        check("async addr/din", int'({pa1, din1}), 0);
        check("async done/chk", int'({done1, chk1}), exp_chk(0));
        @(negedge clk);
        rst_n = 1;
        end_session();
        check("pending lost", int'(we1), 0);

        check("one-hot we", multi, 0);
        check("stable addr/din", unstable, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
